dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache between the load/store buffer (LSB) and the byte-wide memory arbiter. Accepts one LB/LH/LW/SB/SH/SW request at a time from the LSB, answers with a one-cycle feedback pulse, and bypasses the cache for the I/O region (addr[17:16] == 2'b11). It never sees ROB flushes: every accepted request runs to completion and is reported.

## Interface
- INDEX_BITS, 5: line index width (2^INDEX_BITS lines of 4 bytes); tag = addr[17:INDEX_BITS+2]
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rw_en  in  1  LSB request valid (accept rule in Operation)
- write_mode  in  1  1 = store, 0 = load
- width  in  2  0 byte, 1 half, 2 word (3 illegal)
- sign_ext  in  1  loads: sign-extend (1) or zero-extend (0)
- addr  in  18  byte address, naturally aligned to width
- value  in  32  store data, low bytes used
- idle  out  1  high in IDLE state
- rw_feedback_en  out  1  one-cycle completion pulse
- load_val  out  32  load result, valid with rw_feedback_en (0 for stores)
- mem_req  out  1  byte access request to arbiter
- mem_wr  out  1  1 = byte write
- mem_addr  out  18  byte address
- mem_dout  out  8  write byte
- mem_gnt  in  1  access performed this cycle when mem_req && mem_gnt
- mem_din  in  8  read byte, valid the cycle after a granted read

## Operation
- Accept: rw_en sampled high while idle || rw_feedback_en; request latched. rw_en in any other cycle is a protocol error (simulation-only fatal).
- States: IDLE -> LOOKUP -> {IDLE, MEM_RD, MEM_WR}; MEM_RD/MEM_WR -> IDLE.
- LOOKUP: hit = valid[idx] && tag[idx] == req tag && not I/O.
  - Load hit: extract, extend, pulse feedback, go IDLE.
  - Load miss (cacheable): MEM_RD fetching bytes {line,00}..{line,11} in order.
  - I/O load: MEM_RD fetching only width bytes from addr upward; no array access.
  - Store (any): MEM_WR writing width bytes from addr upward (little-endian, value[7:0] first). Cacheable hit also merges bytes into the line at LOOKUP; miss leaves arrays untouched.
- MEM_RD: 2-bit issue counter advances per grant; receive counter advances when byte arrives (cycle after grant). After last byte: cacheable fill writes line, sets valid, tag; result extracted from assembled word; feedback; IDLE.
- MEM_WR: after last write grant, feedback next cycle; IDLE.
- Extract: byte at addr[1:0], half at addr[1]; extend per sign_ext; word unchanged.
- mem_* combinational from state and issue counter; mem_req low outside MEM_RD/MEM_WR and once all bytes are issued.

## Timing
- Reset: state IDLE, all valid bits 0, counters 0, rw_feedback_en 0, load_val 0; mem_req 0, mem_wr 0, mem_addr 0, mem_dout 0 result. idle 1 the cycle after reset.
- Reset mid-operation: in-flight request dropped, no feedback pulse, arrays invalidated.
- With mem_gnt always high, request accepted at edge ending cycle T:
  - Load hit: feedback in T+2.
  - Line fill: grants T+2..T+5, bytes T+3..T+6, feedback T+7.
  - Store word: grants T+2..T+5, feedback T+6; store byte: feedback T+3.
  - I/O byte load: grant T+2, data T+3, feedback T+4.
- mem_gnt low stalls the issue counter; mem_addr/mem_dout held stable until granted.
- Back-to-back: request accepted in feedback cycle enters LOOKUP next cycle; a store in LOOKUP updates the line before a following load looks it up.
- Index wrap: lines 0 and 2^INDEX_BITS-1 have no special case; conflicting tags simply evict on fill.

## Structure
- dcache_pkg: width encodings, state enum, IO_PREFIX = 2'b11, ADDR_BITS = 18, offset/index/tag field helpers.
- Sub-module dcache_align: combinational byte/half extraction and sign/zero extension from a 32-bit word, addr[1:0], width, sign_ext; reused for hit and fill paths.

## Test plan
- Reset, then LW 0x00100 with mem holding 0x44332211 -> mem reads 0x00100..0x00103, load_val 0x44332211 in T+7; repeat LW -> no mem_req, feedback T+2.
- LB sign_ext=1 at 0x00103 after fill of 0x80FF7F01 -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x00102 signed -> 0xFFFF80FF.
- SH 0xBEEF at 0x00102 on hit line -> byte writes 0xEF@0x00102, 0xBE@0x00103, feedback T+4; then LW 0x00100 hits -> 0xBEEF7F01.
- SB to 0x30000 (I/O) then LB 0x30004 -> one mem write, one mem read, no valid bit changes; following LW 0x00100 still hits.
- mem_gnt low for 3 cycles during fill -> mem_addr held, feedback delayed exactly 3 cycles, value correct.
- Load hit issued in the same cycle as previous feedback -> accepted, feedback two cycles later; rst asserted during MEM_RD -> no feedback, next LW misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, state enum and address-field helpers for the data cache
package dcache_pkg;

  localparam int ADDR_BITS = 18;
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR
  } state_e;

  function automatic logic [1:0] addr_offset(input logic [ADDR_BITS-1:0] a);
    return a[1:0];
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] a,
                                                      input int index_bits);
    return (a >> 2) & ((ADDR_BITS'(1) << index_bits) - ADDR_BITS'(1));
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] a,
                                                    input int index_bits);
    return a >> (index_bits + 2);
  endfunction

  function automatic logic is_io(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1 -: 2] == IO_PREFIX;
  endfunction

  // Illegal width 3 is treated as a word access.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dcache_align.sv
// rtl/dcache_align.sv - byte/half extraction and sign/zero extension from a 32-bit word
module dcache_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (width)
      W_BYTE:  result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      W_HALF:  result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through, no-write-allocate data cache with I/O bypass
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rw_en,
  input  logic        write_mode,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  input  logic [17:0] addr,
  input  logic [31:0] value,
  output logic        idle,
  output logic        rw_feedback_en,
  output logic [31:0] load_val,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - 2 - INDEX_BITS;

  state_e      state_q, state_d;
  logic        req_wr_q, req_wr_d;
  logic [1:0]  req_width_q, req_width_d;
  logic        req_sext_q, req_sext_d;
  logic [17:0] req_addr_q, req_addr_d;
  logic [31:0] req_value_q, req_value_d;
  logic [1:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  recv_cnt_q, recv_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic        rd_pending_q, rd_pending_d;
  logic [31:0] asm_q, asm_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic        fb_q, fb_d;
  logic [31:0] load_val_q, load_val_d;

  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic        req_io, fill_mode, hit;
  logic [2:0]  req_nbytes;
  logic [1:0]  last_cnt, recv_pos, merge_pos;
  logic [17:0] base_addr;
  logic [31:0] line_word, store_merged, align_in, align_out, data_wdata;
  logic        data_we, tag_we;

  assign req_idx    = INDEX_BITS'(addr_index(req_addr_q, INDEX_BITS));
  assign req_tag    = TAG_W'(addr_tag(req_addr_q, INDEX_BITS));
  assign req_io     = is_io(req_addr_q);
  // Cacheable load misses always fetch the full line starting at offset 0.
  assign fill_mode  = !req_wr_q && !req_io;
  assign req_nbytes = fill_mode ? 3'd4 : width_bytes(req_width_q);
  assign last_cnt   = 2'(req_nbytes - 3'd1);
  assign base_addr  = fill_mode ? {req_addr_q[17:2], 2'b00} : req_addr_q;
  assign recv_pos   = base_addr[1:0] + recv_cnt_q;
  assign line_word  = data_mem[req_idx];
  assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !req_io;

  assign idle           = (state_q == S_IDLE);
  assign rw_feedback_en = fb_q;
  assign load_val       = load_val_q;

  dcache_align u_align (
    .word     (align_in),
    .offset   (req_addr_q[1:0]),
    .width    (req_width_q),
    .sign_ext (req_sext_q),
    .result   (align_out)
  );

  always_comb begin
    store_merged = line_word;
    merge_pos    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      merge_pos = addr_offset(req_addr_q) + 2'(k);
      if (3'(k) < req_nbytes) begin
        store_merged[{merge_pos, 3'b000} +: 8] = req_value_q[8*k +: 8];
      end
    end
  end

  // Bytes land at their in-word position so one extraction path serves fills and I/O loads.
  always_comb begin
    asm_d = asm_q;
    if (rd_pending_q) begin
      asm_d[{recv_pos, 3'b000} +: 8] = mem_din;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_wr_d     = req_wr_q;
    req_width_d  = req_width_q;
    req_sext_d   = req_sext_q;
    req_addr_d   = req_addr_q;
    req_value_d  = req_value_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    issue_done_d = issue_done_q;
    rd_pending_d = 1'b0;
    valid_d      = valid_q;
    fb_d         = 1'b0;
    load_val_d   = 32'd0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 18'd0;
    mem_dout     = 8'd0;
    data_we      = 1'b0;
    data_wdata   = store_merged;
    tag_we       = 1'b0;
    align_in     = asm_d;

    case (state_q)
      S_IDLE: begin
        issue_cnt_d  = 2'd0;
        recv_cnt_d   = 2'd0;
        issue_done_d = 1'b0;
        if (rw_en) begin
          req_wr_d    = write_mode;
          req_width_d = width;
          req_sext_d  = sign_ext;
          req_addr_d  = addr;
          req_value_d = value;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        align_in = line_word;
        if (req_wr_d) begin
          data_we = hit;
          state_d = S_MEM_WR;
        end else if (hit) begin
          fb_d       = 1'b1;
          load_val_d = align_out;
          state_d    = S_IDLE;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req  = !issue_done_q;
        mem_addr = base_addr + 18'(issue_cnt_q);
        if (mem_req && mem_gnt) begin
          issue_cnt_d  = issue_cnt_q + 2'd1;
          rd_pending_d = 1'b1;
          if (issue_cnt_q == last_cnt) begin
            issue_done_d = 1'b1;
          end
        end
        if (rd_pending_q) begin
          recv_cnt_d = recv_cnt_q + 2'd1;
          if (recv_cnt_q == last_cnt) begin
            fb_d       = 1'b1;
            load_val_d = align_out;
            state_d    = S_IDLE;
            if (fill_mode) begin
              data_we          = 1'b1;
              data_wdata       = asm_d;
              tag_we           = 1'b1;
              valid_d[req_idx] = 1'b1;
            end
          end
        end
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = req_addr_q + 18'(issue_cnt_q);
        mem_dout = req_value_q[{issue_cnt_q, 3'b000} +: 8];
        if (mem_gnt) begin
          issue_cnt_d = issue_cnt_q + 2'd1;
          if (issue_cnt_q == last_cnt) begin
            fb_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_wr_q     <= 1'b0;
      req_width_q  <= 2'd0;
      req_sext_q   <= 1'b0;
      req_addr_q   <= 18'd0;
      req_value_q  <= 32'd0;
      issue_cnt_q  <= 2'd0;
      recv_cnt_q   <= 2'd0;
      issue_done_q <= 1'b0;
      rd_pending_q <= 1'b0;
      asm_q        <= 32'd0;
      valid_q      <= '0;
      fb_q         <= 1'b0;
      load_val_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_wr_q     <= req_wr_d;
      req_width_q  <= req_width_d;
      req_sext_q   <= req_sext_d;
      req_addr_q   <= req_addr_d;
      req_value_q  <= req_value_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      issue_done_q <= issue_done_d;
      rd_pending_q <= rd_pending_d;
      asm_q        <= asm_d;
      valid_q      <= valid_d;
      fb_q         <= fb_d;
      load_val_q   <= load_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && data_we) begin
      data_mem[req_idx] <= data_wdata;
    end
    if (!rst && tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

  a_req_when_ready: assert property (@(posedge clk) disable iff (rst)
      rw_en |-> (idle || rw_feedback_en))
    else $fatal(1, "dcache: rw_en raised while a request is in flight");

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - self-checking bench for dcache against a byte-memory reference model
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw_en = 1'b0;
  logic        write_mode = 1'b0;
  logic [1:0]  width = 2'd0;
  logic        sign_ext = 1'b0;
  logic [17:0] addr = 18'd0;
  logic [31:0] value = 32'd0;
  logic        idle, rw_feedback_en, mem_req, mem_wr;
  logic [31:0] load_val;
  logic [17:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_gnt = 1'b1;
  logic [7:0]  mem_din = 8'd0;

  int tests = 0;
  int failed = 0;

  logic [7:0]  bus_mem [0:262143];
  logic [7:0]  ref_mem [0:262143];
  bit          ref_valid [32];
  int          ref_tag [32];
  logic [26:0] acc_q [$];

  dcache #(.INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst), .rw_en(rw_en), .write_mode(write_mode), .width(width),
    .sign_ext(sign_ext), .addr(addr), .value(value), .idle(idle),
    .rw_feedback_en(rw_feedback_en), .load_val(load_val), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_gnt(mem_gnt),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_wr) begin
        bus_mem[mem_addr] <= mem_dout;
        acc_q.push_back({1'b1, mem_addr, mem_dout});
      end else begin
        mem_din <= bus_mem[mem_addr];
        acc_q.push_back({1'b0, mem_addr, bus_mem[mem_addr]});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke_word(input logic [17:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus_mem[a + 18'(i)] = w[8*i +: 8];
      ref_mem[a + 18'(i)] = w[8*i +: 8];
    end
  endtask

  // Called at a negedge where the cache is idle or pulsing feedback; returns at the
  // negedge of the feedback cycle so the next request can follow back-to-back.
  // gmode: 0 grant always, 1 random grant, 2 grant low for 3 cycles from stall_at.
  task automatic run_req(input logic wr, input logic [1:0] w, input logic sx,
                         input logic [17:0] a, input logic [31:0] v,
                         input int gmode, input int stall_at, input string tag);
    logic [26:0] exp_q [$];
    int          n, idx, tg, exp_lat, lat, bad;
    logic        io, is_hit;
    logic [63:0] raw;
    logic [31:0] exp_val;
    logic [17:0] line_base;
    n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    io = (a[17:16] == 2'b11);
    idx = int'(a >> 2) % 32;
    tg = int'(a >> 7);
    line_base = a & ~18'd3;
    is_hit = !io && ref_valid[idx] && (ref_tag[idx] == tg);
    exp_val = 32'd0;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({1'b1, a + 18'(i), v[8*i +: 8]});
        ref_mem[a + 18'(i)] = v[8*i +: 8];
      end
      exp_lat = 2 + n;
    end else begin
      raw = 64'd0;
      for (int i = 0; i < n; i++) raw = raw | (64'(ref_mem[a + 18'(i)]) << (8 * i));
      if (sx && n < 4 && raw[8*n-1]) raw = raw | ~((64'd1 << (8 * n)) - 64'd1);
      exp_val = raw[31:0];
      if (is_hit) begin
        exp_lat = 2;
      end else if (io) begin
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, a + 18'(i), ref_mem[a + 18'(i)]});
        exp_lat = 3 + n;
      end else begin
        for (int i = 0; i < 4; i++)
          exp_q.push_back({1'b0, line_base + 18'(i), ref_mem[line_base + 18'(i)]});
        exp_lat = 7;
        ref_valid[idx] = 1'b1;
        ref_tag[idx] = tg;
      end
    end
    if (gmode == 2) exp_lat += 3;

    acc_q.delete();
    rw_en = 1'b1; write_mode = wr; width = w; sign_ext = sx; addr = a; value = v;
    @(negedge clk);
    rw_en = 1'b0;
    lat = 1;
    forever begin
      if (gmode == 1) mem_gnt = 1'($urandom_range(0, 1));
      else if (gmode == 2) mem_gnt = !(lat >= stall_at && lat < stall_at + 3);
      else mem_gnt = 1'b1;
      if (gmode == 2 && lat == stall_at + 2) begin
        check({tag, "_stall_req"}, 32'(mem_req), 32'd1);
        check({tag, "_stall_addr"}, 32'(mem_addr), 32'(line_base + 18'(stall_at - 2)));
      end
      if (rw_feedback_en === 1'b1 || lat >= 80) break;
      @(negedge clk);
      lat++;
    end
    mem_gnt = 1'b1;

    check({tag, "_feedback"}, 32'(rw_feedback_en), 32'd1);
    if (gmode != 1) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_load_val"}, load_val, exp_val);
    check({tag, "_acc_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad < 0 && (i >= acc_q.size() || acc_q[i] !== exp_q[i])) bad = i;
    end
    check({tag, "_acc_first_bad"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  initial begin
    int fb_count;
    logic [17:0] ra;
    logic [1:0]  rw_w;
    int idx_pick [4];
    idx_pick[0] = 0; idx_pick[1] = 1; idx_pick[2] = 30; idx_pick[3] = 31;

    for (int i = 0; i < 262144; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i] = 0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_feedback", 32'(rw_feedback_en), 32'd0);
    check("rst_load_val", load_val, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);

    poke_word(18'h00100, 32'h44332211);
    run_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 0, 0, "lw_fill");
    run_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 0, 0, "lw_hit");

    run_req(1'b0, 2'd2, 1'b0, 18'h00180, 32'd0, 0, 0, "lw_evict");
    poke_word(18'h00100, 32'h80FF7F01);
    run_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 0, 0, "lw_refill");
    run_req(1'b0, 2'd0, 1'b1, 18'h00103, 32'd0, 0, 0, "lb_signed");
    run_req(1'b0, 2'd0, 1'b0, 18'h00103, 32'd0, 0, 0, "lbu");
    run_req(1'b0, 2'd1, 1'b1, 18'h00102, 32'd0, 0, 0, "lh_signed");

    run_req(1'b1, 2'd1, 1'b0, 18'h00102, 32'h0000BEEF, 0, 0, "sh_hit");
    run_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 0, 0, "lw_after_sh");

    run_req(1'b1, 2'd0, 1'b0, 18'h30000, 32'h000000A5, 0, 0, "sb_io");
    run_req(1'b0, 2'd0, 1'b0, 18'h30004, 32'd0, 0, 0, "lb_io");
    run_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 0, 0, "lw_still_hit");

    run_req(1'b1, 2'd2, 1'b0, 18'h00104, 32'hCAFEF00D, 0, 0, "sw_miss");
    run_req(1'b0, 2'd2, 1'b0, 18'h00200, 32'd0, 2, 3, "lw_stall");

    acc_q.delete();
    rw_en = 1'b1; write_mode = 1'b0; width = 2'd2; sign_ext = 1'b0;
    addr = 18'h00300; value = 32'd0;
    @(negedge clk);
    rw_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    fb_count = 0;
    repeat (10) begin
      @(negedge clk);
      if (rw_feedback_en === 1'b1) fb_count++;
    end
    check("rst_mid_no_feedback", 32'(fb_count), 32'd0);
    check("rst_mid_idle", 32'(idle), 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 18'h00200, 32'd0, 0, 0, "lw_after_rst");

    for (int t = 0; t < 150; t++) begin
      rw_w = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        ra = {2'b11, 16'($urandom)};
      end else begin
        ra = {11'($urandom_range(0, 3) * 5), 5'(idx_pick[$urandom_range(0, 3)]), 2'($urandom)};
      end
      if (rw_w == 2'd1) ra[0] = 1'b0;
      if (rw_w == 2'd2) ra[1:0] = 2'b00;
      run_req(1'($urandom_range(0, 1)), rw_w, 1'($urandom_range(0, 1)), ra, $urandom,
              int'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", t));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
